vmem_arbiter: RTL and testbench
===============================

VMEM_ARBITER -- requirements
Module: vmem_arbiter

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 12, video-memory word address width.
REQ-002 The module SHALL have parameter DATA_W, default 32, video-memory word width.
REQ-003 The module SHALL have parameter WBUF_DEPTH, default 4, CPU write-buffer entries (power of two, 2..16).
REQ-004 lcd_clk  input  1  clock; all logic SHALL be on its rising edge.
REQ-005 sys_rst  input  1  reset, asynchronous, active-low.
REQ-006 disp_en  input  1  display fetch request, high inside the character window.
REQ-007 disp_addr  input  ADDR_W  display read address, the lrom_offset plus row offset.
REQ-008 disp_data  output  DATA_W  display read data, equal to mem_rdata.
REQ-009 disp_valid  output  1  disp_data holds the word requested on the previous cycle.
REQ-010 cpu_wr_valid  input  1  CPU write request.
REQ-011 cpu_wr_addr  input  ADDR_W  CPU write address.
REQ-012 cpu_wr_data  input  DATA_W  CPU write data.
REQ-013 cpu_wr_ready  output  1  write buffer can accept; a write transfers when cpu_wr_valid and cpu_wr_ready are both high.
REQ-014 mem_en, mem_we  output  1 each  single-port memory enable and write enable.
REQ-015 mem_addr  output  ADDR_W  memory address.
REQ-016 mem_wdata  output  DATA_W  memory write data.
REQ-017 mem_rdata  input  DATA_W  memory read data, one-cycle read latency.
REQ-018 wbuf_level  output  5  number of occupied write-buffer entries.

Function
REQ-019 The FSM SHALL have the states IDLE, DISP, TURN and DRAIN.
REQ-020 disp_en SHALL have absolute priority: in any cycle with disp_en=1, mem_en=1, mem_we=0 and mem_addr=disp_addr, combinationally and in every state.
REQ-021 Transitions SHALL be:
  - any state -> DISP when disp_en=1;
  - DISP -> TURN when disp_en=0;
  - TURN -> DRAIN when the buffer is non-empty, else TURN -> IDLE;
  - IDLE -> DRAIN when the buffer is non-empty;
  - DRAIN -> IDLE when the last entry is popped.
REQ-022 TURN SHALL last exactly one cycle, with mem_en=0, as the read/write turnaround.
REQ-023 In DRAIN with disp_en=0, each cycle SHALL pop the buffer head and drive mem_en=1, mem_we=1, mem_addr and mem_wdata from that entry, one write per cycle.
REQ-024 In IDLE with an empty buffer and in TURN, mem_en SHALL be 0; mem_addr and mem_wdata are don't-care.
REQ-025 disp_valid SHALL be disp_en registered by one cycle.
REQ-026 The write buffer SHALL be FIFO, with writes retired in acceptance order.
REQ-027 cpu_wr_ready SHALL be 1 exactly when wbuf_level < WBUF_DEPTH, derived from registered state.
REQ-028 Push and pop in the same cycle SHALL leave wbuf_level unchanged.
REQ-029 When the buffer is full and a pop occurs, cpu_wr_ready SHALL rise only in the following cycle.
REQ-030 Pointers SHALL wrap modulo WBUF_DEPTH; wbuf_level SHALL never exceed WBUF_DEPTH or go below 0.
REQ-031 A write accepted while in DISP SHALL be held until after TURN; a pending pop SHALL be suppressed in any cycle with disp_en=1.

Reset
REQ-032 While sys_rst=0:
  - state = IDLE;
  - buffer pointers and wbuf_level = 0;
  - disp_valid = 0, mem_en = 0, mem_we = 0;
  - cpu_wr_ready = 1 in the first cycle after release.
REQ-033 Reset mid-operation SHALL discard all buffered writes.
REQ-034 No memory write SHALL occur in the cycle sys_rst is asserted.

Configuration
REQ-035 Macro VMEM_ARB_STATS_EN defined: the module SHALL add two outputs.
  - stat_wr_cnt (16 bits): memory writes retired.
  - stat_stall_cnt (16 bits): cycles with cpu_wr_valid=1 and cpu_wr_ready=0.
  - Both counters SHALL saturate at 16'hFFFF and reset to 0.
REQ-036 Macro VMEM_ARB_STATS_EN undefined: those ports and counters SHALL be absent, with all other behaviour identical.

Verification
REQ-037 Reset release, two CPU writes (0x010<-0xA5A5A5A5, 0x011<-0x5A5A5A5A), disp_en=0 -> two consecutive memory writes in accept order, then wbuf_level=0 and IDLE.
REQ-038 disp_en=1 for 256 cycles with disp_addr counting 0x000.. -> mem_we=0 throughout; disp_valid high cycles 1..256 after start; disp_data matches ROM model.
REQ-039 Four CPU writes during DISP, then a fifth -> cpu_wr_ready=0 at level 4; no write until TURN ends; four writes then retire in order.
REQ-040 disp_en rises mid-DRAIN with 3 entries left -> read wins that cycle and no write is lost; the remaining writes complete after TURN.
REQ-041 Full buffer, then sys_rst pulsed low mid-DRAIN -> no further writes; wbuf_level=0; cpu_wr_ready=1 after release.
REQ-042 With VMEM_ARB_STATS_EN defined, 3 writes plus 5 stalled cycles -> stat_wr_cnt=3, stat_stall_cnt=5.

Source files
------------

// File: rtl/vmem_arbiter.sv
// vmem_arbiter: single-port video-memory arbiter between the display fetch path
// and a buffered CPU write path. Display reads always win; CPU writes are queued
// in a small FIFO and drained only when the display is idle, after a turnaround.
//
// Ports:
//   lcd_clk, sys_rst           clock (rising edge) and async active-low reset
//   disp_en/disp_addr          display read request and address (combinational to memory)
//   disp_data/disp_valid       read data (mem_rdata pass-through) and its one-cycle-late qualifier
//   cpu_wr_valid/addr/data     CPU write request, accepted when cpu_wr_ready is high
//   cpu_wr_ready               write buffer has a free entry (from registered level only)
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata   single-port memory, one-cycle read latency
//   wbuf_level                 occupied write-buffer entries
//   stat_wr_cnt/stat_stall_cnt present only when VMEM_ARB_STATS_EN is defined:
//                              saturating counts of retired writes and stalled CPU cycles
//
// Optional feature macro: VMEM_ARB_STATS_EN

module vmem_arbiter #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 32,
  parameter int WBUF_DEPTH = 4
) (
  input  logic              lcd_clk,
  input  logic              sys_rst,
  input  logic              disp_en,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid,
  input  logic              cpu_wr_valid,
  input  logic [ADDR_W-1:0] cpu_wr_addr,
  input  logic [DATA_W-1:0] cpu_wr_data,
  output logic              cpu_wr_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [4:0]        wbuf_level
`ifdef VMEM_ARB_STATS_EN
  ,
  output logic [15:0]       stat_wr_cnt,
  output logic [15:0]       stat_stall_cnt
`endif
);

  localparam int         PTR_W   = $clog2(WBUF_DEPTH);
  localparam logic [4:0] DEPTH_L = 5'(WBUF_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DISP,
    S_TURN,
    S_DRAIN
  } state_t;

  state_t state, state_nxt;

  // Write buffer storage and bookkeeping
  logic [ADDR_W-1:0] buf_addr [WBUF_DEPTH];
  logic [DATA_W-1:0] buf_data [WBUF_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [4:0]        level;

  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;

  // Ready comes only from the registered level, so a pop from a full buffer
  // frees the slot for the CPU one cycle later, never in the same cycle.
  assign cpu_wr_ready = (level < DEPTH_L);
  assign push         = cpu_wr_valid & cpu_wr_ready;
  assign wbuf_level   = level;

  assign head_addr = buf_addr[rd_ptr];
  assign head_data = buf_data[rd_ptr];

  // Display read data is the raw memory output; disp_valid tags it.
  assign disp_data = mem_rdata;

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge lcd_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state, pop decision and memory port drive
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = head_addr;
    mem_wdata = head_data;

    case (state)
      S_IDLE: begin
        if (level != 5'd0) state_nxt = S_DRAIN;
      end
      S_DISP: begin
        // Only reached here with disp_en low: start the turnaround.
        state_nxt = S_TURN;
      end
      S_TURN: begin
        state_nxt = (level != 5'd0) ? S_DRAIN : S_IDLE;
      end
      S_DRAIN: begin
        pop = (level != 5'd0);
        // A simultaneous push keeps the buffer non-empty, so stay draining.
        if (level == 5'd1 && !push) state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    // Display fetch overrides everything: no write can be retired this cycle.
    if (disp_en) begin
      state_nxt = S_DISP;
      pop       = 1'b0;
    end

    // Guard against a write in the very cycle reset is asserted.
    if (!sys_rst) begin
      pop = 1'b0;
    end

    if (sys_rst) begin
      if (disp_en) begin
        mem_en   = 1'b1;
        mem_addr = disp_addr;
      end else if (pop) begin
        mem_en = 1'b1;
        mem_we = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Write buffer pointers and level
  // ---------------------------------------------------------------------------
  always_ff @(posedge lcd_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= 5'd0;
    end else begin
      // Pointers are log2(depth) wide, so increments wrap naturally.
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   level <= level + 5'd1;
        2'b01:   level <= level - 5'd1;
        default: level <= level;
      endcase
    end
  end

  // Entry storage needs no reset: the pointers define what is valid.
  always_ff @(posedge lcd_clk) begin
    if (push) begin
      buf_addr[wr_ptr] <= cpu_wr_addr;
      buf_data[wr_ptr] <= cpu_wr_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Display read qualifier: matches the one-cycle memory read latency
  // ---------------------------------------------------------------------------
  always_ff @(posedge lcd_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      disp_valid <= 1'b0;
    end else begin
      disp_valid <= disp_en;
    end
  end

`ifdef VMEM_ARB_STATS_EN
  // ---------------------------------------------------------------------------
  // Saturating activity counters
  // ---------------------------------------------------------------------------
  logic stall;
  assign stall = cpu_wr_valid & ~cpu_wr_ready;

  always_ff @(posedge lcd_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      stat_wr_cnt    <= 16'd0;
      stat_stall_cnt <= 16'd0;
    end else begin
      if (pop && stat_wr_cnt != 16'hFFFF) begin
        stat_wr_cnt <= stat_wr_cnt + 16'd1;
      end
      if (stall && stat_stall_cnt != 16'hFFFF) begin
        stat_stall_cnt <= stat_stall_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_vmem_arbiter.sv
// Testbench for vmem_arbiter: scenario tasks with inline checks, a behavioural
// memory model, and a queue-based write-order reference model.
module tb_vmem_arbiter;
  localparam int AW    = 12;
  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic          lcd_clk;
  logic          sys_rst;
  logic          disp_en;
  logic [AW-1:0] disp_addr;
  logic [DW-1:0] disp_data;
  logic          disp_valid;
  logic          cpu_wr_valid;
  logic [AW-1:0] cpu_wr_addr;
  logic [DW-1:0] cpu_wr_data;
  logic          cpu_wr_ready;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic [4:0]    wbuf_level;
`ifdef VMEM_ARB_STATS_EN
  logic [15:0]   stat_wr_cnt;
  logic [15:0]   stat_stall_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int disp_viol = 0;
  logic load_rom = 1'b0;

  logic [DW-1:0] vram [1 << AW];

  // Reference model: writes expected in acceptance order; log of actual writes.
  logic [AW-1:0] exp_addr [$];
  logic [DW-1:0] exp_data [$];
  logic [AW-1:0] log_addr [$];
  logic [DW-1:0] log_data [$];
  int            log_cyc  [$];

  vmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WBUF_DEPTH(DEPTH)) dut (
    .lcd_clk      (lcd_clk),
    .sys_rst      (sys_rst),
    .disp_en      (disp_en),
    .disp_addr    (disp_addr),
    .disp_data    (disp_data),
    .disp_valid   (disp_valid),
    .cpu_wr_valid (cpu_wr_valid),
    .cpu_wr_addr  (cpu_wr_addr),
    .cpu_wr_data  (cpu_wr_data),
    .cpu_wr_ready (cpu_wr_ready),
    .mem_en       (mem_en),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .wbuf_level   (wbuf_level)
`ifdef VMEM_ARB_STATS_EN
    ,
    .stat_wr_cnt   (stat_wr_cnt),
    .stat_stall_cnt(stat_stall_cnt)
`endif
  );

  initial lcd_clk = 1'b0;
  always #5 lcd_clk = ~lcd_clk;

  always @(posedge lcd_clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] rom_word(input int a);
    return (32'(a) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  // Single-port memory with one-cycle read latency
  always @(posedge lcd_clk) begin
    if (load_rom) begin
      for (int i = 0; i < (1 << AW); i++) vram[i] <= rom_word(i);
    end else if (mem_en === 1'b1) begin
      if (mem_we === 1'b1) vram[mem_addr] <= mem_wdata;
      else                 mem_rdata <= vram[mem_addr];
    end
  end

  // Observe the memory port mid-cycle
  always @(negedge lcd_clk) begin
    if (mem_en === 1'b1 && mem_we === 1'b1) begin
      log_addr.push_back(mem_addr);
      log_data.push_back(mem_wdata);
      log_cyc.push_back(cyc);
    end
    if (sys_rst === 1'b1 && disp_en === 1'b1 &&
        !(mem_en === 1'b1 && mem_we === 1'b0 && mem_addr === disp_addr))
      disp_viol++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge lcd_clk);
    #1;
  endtask

  task automatic clear_all();
    exp_addr.delete(); exp_data.delete();
    log_addr.delete(); log_data.delete(); log_cyc.delete();
  endtask

  // One write attempt lasting one cycle; recorded as expected if the handshake completes.
  task automatic push_cycle(input logic [AW-1:0] a, input logic [DW-1:0] d);
    cpu_wr_valid = 1'b1; cpu_wr_addr = a; cpu_wr_data = d;
    @(negedge lcd_clk);
    if (cpu_wr_ready === 1'b1) begin
      exp_addr.push_back(a);
      exp_data.push_back(d);
    end
    tick();
    cpu_wr_valid = 1'b0;
  endtask

  task automatic fill_in_disp(input int n);
    disp_en = 1'b1;
    for (int i = 0; i < n; i++) begin
      disp_addr = AW'($urandom);
      push_cycle(AW'($urandom), $urandom);
    end
  endtask

  task automatic wait_drain(input int want, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge lcd_clk);
      if (wbuf_level === 5'd0 && log_addr.size() >= want) break;
      tick();
    end
    tick();
  endtask

  function automatic int log_mismatches();
    int m = 0;
    if (log_addr.size() != exp_addr.size()) m++;
    for (int i = 0; i < log_addr.size() && i < exp_addr.size(); i++)
      if (log_addr[i] !== exp_addr[i] || log_data[i] !== exp_data[i]) m++;
    return m;
  endfunction

  task automatic test_reset();
    sys_rst = 1'b0; disp_en = 1'b0; disp_addr = '0;
    cpu_wr_valid = 1'b1; cpu_wr_addr = 12'h3FF; cpu_wr_data = 32'hDEAD_BEEF;
    load_rom = 1'b1;
    tick();
    load_rom = 1'b0;
    @(negedge lcd_clk);
    n_tests++; if (mem_en !== 1'b0) begin n_fail++; $display("FAIL reset_mem_en: got %b want 0", mem_en); end
    n_tests++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
    n_tests++; if (disp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_disp_valid: got %b want 0", disp_valid); end
    n_tests++; if (wbuf_level !== 5'd0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", wbuf_level); end
    tick();
    cpu_wr_valid = 1'b0;
    tick();
    sys_rst = 1'b1;
    @(negedge lcd_clk);
    n_tests++; if (cpu_wr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b want 1", cpu_wr_ready); end
    n_tests++; if (wbuf_level !== 5'd0) begin n_fail++; $display("FAIL reset_release_level: got %0d want 0", wbuf_level); end
    tick();
    clear_all();
  endtask

  task automatic test_disp_read();
    int verr = 0, derr = 0, v0 = disp_viol;
    clear_all();
    for (int k = 0; k < 258; k++) begin
      if (k < 256) begin disp_en = 1'b1; disp_addr = AW'(k); end
      else disp_en = 1'b0;
      @(negedge lcd_clk);
      if (disp_valid !== ((k >= 1 && k <= 256) ? 1'b1 : 1'b0)) verr++;
      if (k >= 1 && k <= 256 && disp_data !== rom_word(k - 1)) derr++;
      tick();
    end
    n_tests++; if (verr != 0) begin n_fail++; $display("FAIL disp_valid_window: %0d bad cycles, want 0", verr); end
    n_tests++; if (derr != 0) begin n_fail++; $display("FAIL disp_data_rom: %0d bad words, want 0", derr); end
    n_tests++; if (disp_viol != v0) begin n_fail++; $display("FAIL disp_priority: %0d bad cycles, want 0", disp_viol - v0); end
    n_tests++; if (log_addr.size() != 0) begin n_fail++; $display("FAIL disp_no_write: got %0d writes want 0", log_addr.size()); end
  endtask

  task automatic test_basic_writes();
    int c0;
    clear_all();
    disp_en = 1'b0;
    c0 = cyc;
    push_cycle(12'h010, 32'hA5A5_A5A5);
    push_cycle(12'h011, 32'h5A5A_5A5A);
    wait_drain(2, 20);
    n_tests++; if (log_mismatches() != 0) begin n_fail++; $display("FAIL basic_order: %0d mismatches (got %0d writes, want 2)", log_mismatches(), log_addr.size()); end
    n_tests++;
    if (log_cyc.size() != 2) begin n_fail++; $display("FAIL basic_timing: got %0d writes want 2", log_cyc.size()); end
    else if (log_cyc[0] != c0 + 2 || log_cyc[1] != c0 + 3) begin
      n_fail++; $display("FAIL basic_timing: writes at +%0d,+%0d want +2,+3", log_cyc[0] - c0, log_cyc[1] - c0);
    end
    @(negedge lcd_clk);
    n_tests++; if (wbuf_level !== 5'd0) begin n_fail++; $display("FAIL basic_level: got %0d want 0", wbuf_level); end
    n_tests++; if (mem_en !== 1'b0) begin n_fail++; $display("FAIL basic_idle: mem_en got %b want 0", mem_en); end
    tick();
  endtask

  task automatic test_disp_fill();
    int c0, serr = 0;
    logic [AW-1:0] a5 = 12'h7E5;
    logic [DW-1:0] d5 = 32'h0F0F_1234;
    clear_all();
    fill_in_disp(4);
    cpu_wr_valid = 1'b1; cpu_wr_addr = a5; cpu_wr_data = d5;
    @(negedge lcd_clk);
    n_tests++; if (wbuf_level !== 5'd4) begin n_fail++; $display("FAIL fill_level: got %0d want 4", wbuf_level); end
    n_tests++; if (cpu_wr_ready !== 1'b0) begin n_fail++; $display("FAIL fill_ready: got %b want 0", cpu_wr_ready); end
    tick();
    for (int i = 0; i < 3; i++) begin
      @(negedge lcd_clk);
      if (cpu_wr_ready !== 1'b0) serr++;
      tick();
    end
    n_tests++; if (serr != 0) begin n_fail++; $display("FAIL fill_stall: ready high in %0d cycles, want 0", serr); end
    n_tests++; if (log_addr.size() != 0) begin n_fail++; $display("FAIL fill_hold: got %0d writes during display want 0", log_addr.size()); end
    disp_en = 1'b0;
    c0 = cyc;
    tick();                             // DISP with display released
    @(negedge lcd_clk);                 // turnaround
    n_tests++; if (mem_en !== 1'b0) begin n_fail++; $display("FAIL fill_turn: mem_en got %b want 0", mem_en); end
    tick();
    @(negedge lcd_clk);                 // first pop from full buffer
    n_tests++; if (cpu_wr_ready !== 1'b0) begin n_fail++; $display("FAIL fill_ready_pop: got %b want 0", cpu_wr_ready); end
    tick();
    @(negedge lcd_clk);
    n_tests++; if (cpu_wr_ready !== 1'b1) begin n_fail++; $display("FAIL fill_ready_rise: got %b want 1", cpu_wr_ready); end
    if (cpu_wr_ready === 1'b1) begin exp_addr.push_back(a5); exp_data.push_back(d5); end
    tick();
    cpu_wr_valid = 1'b0;
    wait_drain(5, 20);
    n_tests++; if (log_mismatches() != 0) begin n_fail++; $display("FAIL fill_order: %0d mismatches (got %0d writes, want 5)", log_mismatches(), log_addr.size()); end
    n_tests++;
    if (log_cyc.size() == 0 || log_cyc[0] != c0 + 2) begin
      n_fail++; $display("FAIL fill_first_write: got %0d writes, first at +%0d want +2", log_cyc.size(), (log_cyc.size() == 0) ? -1 : log_cyc[0] - c0);
    end
  endtask

  task automatic test_disp_mid_drain();
    int c1, v0;
    logic [AW-1:0] ra;
    clear_all();
    v0 = disp_viol;
    fill_in_disp(4);
    disp_en = 1'b0;
    tick(); tick(); tick();             // DISP, TURN, first pop
    ra = AW'($urandom);
    disp_en = 1'b1; disp_addr = ra;
    @(negedge lcd_clk);
    n_tests++; if (mem_we !== 1'b0 || mem_en !== 1'b1 || mem_addr !== ra) begin
      n_fail++; $display("FAIL middrain_read_wins: en=%b we=%b addr=%h want en=1 we=0 addr=%h", mem_en, mem_we, mem_addr, ra);
    end
    n_tests++; if (wbuf_level !== 5'd3) begin n_fail++; $display("FAIL middrain_level: got %0d want 3", wbuf_level); end
    tick(); tick();
    disp_en = 1'b0;
    c1 = cyc;
    wait_drain(4, 20);
    n_tests++; if (log_mismatches() != 0) begin n_fail++; $display("FAIL middrain_order: %0d mismatches (got %0d writes, want 4)", log_mismatches(), log_addr.size()); end
    n_tests++;
    if (log_cyc.size() < 2 || log_cyc[1] != c1 + 2) begin
      n_fail++; $display("FAIL middrain_resume: got %0d writes, second at +%0d want +2", log_cyc.size(), (log_cyc.size() < 2) ? -1 : log_cyc[1] - c1);
    end
    n_tests++; if (disp_viol != v0) begin n_fail++; $display("FAIL middrain_priority: %0d bad cycles want 0", disp_viol - v0); end
  endtask

  task automatic test_reset_mid_drain();
    clear_all();
    fill_in_disp(4);
    disp_en = 1'b0;
    tick(); tick(); tick();             // DISP, TURN, one write retired
    sys_rst = 1'b0;
    @(negedge lcd_clk);
    n_tests++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_mid_we: got %b want 0", mem_we); end
    n_tests++; if (wbuf_level !== 5'd0) begin n_fail++; $display("FAIL rst_mid_level: got %0d want 0", wbuf_level); end
    tick(); tick();
    sys_rst = 1'b1;
    @(negedge lcd_clk);
    n_tests++; if (cpu_wr_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ready: got %b want 1", cpu_wr_ready); end
    repeat (8) tick();
    @(negedge lcd_clk);
    n_tests++; if (log_addr.size() != 1 || wbuf_level !== 5'd0) begin
      n_fail++; $display("FAIL rst_mid_discard: got %0d writes level %0d want 1 write level 0", log_addr.size(), wbuf_level);
    end
    tick();
    clear_all();
  endtask

  task automatic test_back_to_back();
    int mdl_level = 0, lerr = 0, rerr = 0, v0;
    clear_all();
    v0 = disp_viol;
    disp_en = 1'b0;
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 7) == 0) disp_en = ~disp_en;
      disp_addr    = AW'($urandom);
      cpu_wr_valid = $urandom_range(0, 1) == 1;
      cpu_wr_addr  = AW'($urandom);
      cpu_wr_data  = $urandom;
      @(negedge lcd_clk);
      if (wbuf_level !== 5'(mdl_level)) lerr++;
      if (cpu_wr_ready !== (mdl_level < DEPTH)) rerr++;
      if (cpu_wr_valid && mdl_level < DEPTH) begin
        exp_addr.push_back(cpu_wr_addr);
        exp_data.push_back(cpu_wr_data);
        mdl_level++;
      end
      if (mem_en === 1'b1 && mem_we === 1'b1) mdl_level--;
      tick();
    end
    disp_en = 1'b0; cpu_wr_valid = 1'b0;
    wait_drain(exp_addr.size(), 40);
    n_tests++; if (lerr != 0) begin n_fail++; $display("FAIL b2b_level: %0d bad cycles want 0", lerr); end
    n_tests++; if (rerr != 0) begin n_fail++; $display("FAIL b2b_ready: %0d bad cycles want 0", rerr); end
    n_tests++; if (log_mismatches() != 0) begin n_fail++; $display("FAIL b2b_order: %0d mismatches (got %0d writes, want %0d)", log_mismatches(), log_addr.size(), exp_addr.size()); end
    n_tests++; if (disp_viol != v0) begin n_fail++; $display("FAIL b2b_priority: %0d bad cycles want 0", disp_viol - v0); end
  endtask

`ifdef VMEM_ARB_STATS_EN
  task automatic test_stats();
    sys_rst = 1'b0; disp_en = 1'b0; cpu_wr_valid = 1'b0;
    tick();
    sys_rst = 1'b1;
    clear_all();
    for (int i = 0; i < 3; i++) push_cycle(AW'($urandom), $urandom);
    wait_drain(3, 20);
    fill_in_disp(4);
    cpu_wr_valid = 1'b1;
    repeat (5) tick();
    cpu_wr_valid = 1'b0;
    @(negedge lcd_clk);
    n_tests++; if (stat_wr_cnt !== 16'd3) begin n_fail++; $display("FAIL stat_wr: got %0d want 3", stat_wr_cnt); end
    n_tests++; if (stat_stall_cnt !== 16'd5) begin n_fail++; $display("FAIL stat_stall: got %0d want 5", stat_stall_cnt); end
    tick();
    disp_en = 1'b0;
    wait_drain(7, 20);
  endtask
`endif

  initial begin
    sys_rst = 1'b0; disp_en = 1'b0; disp_addr = '0;
    cpu_wr_valid = 1'b0; cpu_wr_addr = '0; cpu_wr_data = '0;
    #1;
    test_reset();
    test_disp_read();
    test_basic_writes();
    test_disp_fill();
    test_disp_mid_drain();
    test_reset_mid_drain();
    test_back_to_back();
`ifdef VMEM_ARB_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
